// File: rtl/sirv_gnrl_sync_fifo_pkg.sv
// Shared helpers for the general-purpose synchronous FIFO.
package sirv_gnrl_sync_fifo_pkg;

    // Pointer width: index bits plus one wrap bit.
    function automatic int unsigned fifo_ptr_w(input int unsigned dp);
        return $clog2(dp) + 1;
    endfunction

endpackage

// File: rtl/sirv_gnrl_fifo_ptr.sv
// Wrap-bit pointer counter with synchronous active-low reset and increment enable.
module sirv_gnrl_fifo_ptr #(
    parameter int unsigned PW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc_i,
    output logic [PW-1:0] ptr_o
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Next pointer: advance by one, wrapping naturally modulo 2**PW.
    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = ptr_q + PW'(1);
        end
    end

    // Pointer register, cleared synchronously.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/sirv_gnrl_sync_fifo.sv
// Single-clock valid/ready FIFO with flop-array storage and registered head.
module sirv_gnrl_sync_fifo
    import sirv_gnrl_sync_fifo_pkg::*;
#(
    parameter int unsigned DP        = 4,
    parameter int unsigned DW        = 32,
    parameter int unsigned CUT_READY = 0,
    parameter int unsigned MSKO      = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_vld,
    output logic                   i_rdy,
    input  logic [DW-1:0]          i_dat,
    output logic                   o_vld,
    input  logic                   o_rdy,
    output logic [DW-1:0]          o_dat,
    output logic [$clog2(DP):0]    o_cnt
);

    localparam int unsigned CW = fifo_ptr_w(DP);
    localparam int unsigned AW = CW - 1;

    logic [CW-1:0] wptr;
    logic [CW-1:0] rptr;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic [DW-1:0] mem_q [DP];
    logic [DP-1:0] we_d;

    sirv_gnrl_fifo_ptr #(.PW(CW)) u_wptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (push),
        .ptr_o (wptr)
    );

    sirv_gnrl_fifo_ptr #(.PW(CW)) u_rptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (pop),
        .ptr_o (rptr)
    );

    // Status, handshakes and per-entry write enables.
    always_comb begin
        empty = (wptr == rptr);
        full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
        if (CUT_READY != 0) begin
            i_rdy = ~full;
        end else begin
            i_rdy = ~full | o_rdy;
        end
        o_vld = ~empty;
        push  = i_vld & i_rdy;
        pop   = o_vld & o_rdy;
        o_cnt = wptr - rptr;
        we_d  = '0;
        for (int unsigned k = 0; k < DP; k++) begin
            we_d[k] = push && (wptr[AW-1:0] == AW'(k));
        end
    end

    // Storage: one load-enable register per entry, no reset.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < DP; k++) begin
            if (we_d[k]) begin
                mem_q[k] <= i_dat;
            end
        end
    end

    // Head data, optionally masked to zero while empty.
    always_comb begin
        o_dat = mem_q[rptr[AW-1:0]];
        if ((MSKO != 0) && empty) begin
            o_dat = '0;
        end
    end

endmodule
